// File: rtl/seq_mul_pkg.sv
// Shared types and constants for the 16x16 sequential multiplier.
// Holds the FSM state enum, widths, saturation limits and operand magnitude helper.
package seq_mul_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        FIX  = 2'd2,
        DONE = 2'd3
    } state_t;

    localparam int OP_W   = 16;
    localparam int PROD_W = 32;
    localparam int ITER   = 16;

    localparam logic [PROD_W-1:0] SAT_U   = 32'h0000_FFFF;
    localparam logic [PROD_W-1:0] SAT_POS = 32'h0000_7FFF;
    localparam logic [PROD_W-1:0] SAT_NEG = 32'hFFFF_8000;

    // 0x8000 negates to 0x8000, which read unsigned is the correct 32768.
    function automatic logic [OP_W-1:0] mag(input logic [OP_W-1:0] v,
                                            input logic s);
        return (s && v[OP_W-1]) ? (~v + 1'b1) : v;
    endfunction

endpackage

// File: rtl/mul_add17.sv
// 16-bit carry-lookahead adder (4-bit groups) with carry out as bit 16.
// Ports: a, b = addends; sum = 17-bit result {carry, sum[15:0]}.
module mul_add17
    import seq_mul_pkg::*;
(
    input  logic [OP_W-1:0] a,
    input  logic [OP_W-1:0] b,
    output logic [OP_W:0]   sum
);

    logic [OP_W-1:0] p;
    logic [OP_W-1:0] g;
    logic [OP_W-1:0] c;
    logic [4:0]      gc;
    logic            gp;
    logic            gg;
    logic            ck;

    always_comb begin
        p  = a ^ b;
        g  = a & b;
        c  = '0;
        gc = '0;
        gp = 1'b0;
        gg = 1'b0;
        ck = 1'b0;
        for (int j = 0; j < 4; j++) begin
            // group propagate / generate, then lookahead group carry
            gp = 1'b1;
            gg = 1'b0;
            for (int i = 0; i < 4; i++) begin
                gg = g[4*j+i] | (p[4*j+i] & gg);
                gp = gp & p[4*j+i];
            end
            // carries inside the group expand from the group carry-in
            for (int i = 0; i < 4; i++) begin
                ck = gc[j];
                for (int k = 0; k < i; k++) begin
                    ck = g[4*j+k] | (p[4*j+k] & ck);
                end
                c[4*j+i] = ck;
            end
            gc[j+1] = gg | (gp & gc[j]);
        end
        sum = {gc[4], p ^ c};
    end

endmodule

// File: rtl/seq_mul16.sv
// Sequential 16x16 shift-add multiplier, signed or unsigned, 18-cycle latency.
// Ports: clk, rst_n (sync, active-low), start, sign, a, b -> busy, done, product, overflow.
// Build option: define SEQ_MUL_SAT_EN to clamp product to 16-bit range on overflow.
module seq_mul16
    import seq_mul_pkg::*;
(
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic              sign,
    input  logic [OP_W-1:0]   a,
    input  logic [OP_W-1:0]   b,
    output logic              busy,
    output logic              done,
    output logic [PROD_W-1:0] product,
    output logic              overflow
);

    state_t state;
    state_t state_n;

    logic [OP_W-1:0]   mag_a;
    logic [OP_W-1:0]   acc_hi;
    logic [OP_W-1:0]   mplr;
    logic [4:0]        cnt;
    logic              neg;
    logic              sgn;
    logic              accept;
    logic [OP_W:0]     sum;
    logic [OP_W:0]     step;
    logic [PROD_W-1:0] raw;
    logic [PROD_W-1:0] res;
    logic [PROD_W-1:0] res_out;
    logic              ovf;

    mul_add17 u_add (
        .a   (acc_hi),
        .b   (mag_a),
        .sum (sum)
    );

    always_comb begin
        state_n = state;
        accept  = 1'b0;
        busy    = 1'b0;
        done    = 1'b0;
        unique case (state)
            IDLE: begin
                if (start) begin
                    accept  = 1'b1;
                    state_n = CALC;
                end
            end
            CALC: begin
                busy = 1'b1;
                if (cnt == 5'(ITER - 1)) begin
                    state_n = FIX;
                end
            end
            FIX: begin
                busy    = 1'b1;
                state_n = DONE;
            end
            DONE: begin
                done = 1'b1;
                if (start) begin
                    accept  = 1'b1;
                    state_n = CALC;
                end else begin
                    state_n = IDLE;
                end
            end
            default: state_n = IDLE;
        endcase
    end

    // Skip the add when the multiplier LSB is clear; carry is then 0.
    assign step = mplr[0] ? sum : {1'b0, acc_hi};

    always_comb begin
        raw = {acc_hi, mplr};
        res = neg ? (~raw + 1'b1) : raw;
        if (sgn) begin
            ovf = ~((&res[31:15]) | ~(|res[31:15]));
        end else begin
            ovf = |res[31:16];
        end
        res_out = res;
`ifdef SEQ_MUL_SAT_EN
        if (ovf) begin
            if (!sgn) begin
                res_out = SAT_U;
            end else if (neg) begin
                res_out = SAT_NEG;
            end else begin
                res_out = SAT_POS;
            end
        end
`endif
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state    <= IDLE;
            mag_a    <= '0;
            acc_hi   <= '0;
            mplr     <= '0;
            cnt      <= '0;
            neg      <= 1'b0;
            sgn      <= 1'b0;
            product  <= '0;
            overflow <= 1'b0;
        end else begin
            state <= state_n;
            if (accept) begin
                mag_a  <= mag(a, sign);
                mplr   <= mag(b, sign);
                acc_hi <= '0;
                cnt    <= '0;
                neg    <= sign & (a[OP_W-1] ^ b[OP_W-1]);
                sgn    <= sign;
            end else if (state == CALC) begin
                acc_hi <= step[OP_W:1];
                mplr   <= {step[0], mplr[OP_W-1:1]};
                cnt    <= cnt + 5'd1;
            end else if (state == FIX) begin
                product  <= res_out;
                overflow <= ovf;
            end
        end
    end

endmodule

// File: doc/seq_mul16.md
SEQ_MUL16 -- requirements
Module: seq_mul16

Interface
REQ-001 SHALL have port `clk`, input, 1 bit: single rising-edge clock.
REQ-002 SHALL have port `rst_n`, input, 1 bit: reset, synchronous, active-low.
REQ-003 SHALL have port `start`, input, 1 bit: request to multiply; sampled only when the block is not busy.
REQ-004 SHALL have port `sign`, input, 1 bit: 1 = two's-complement operands, 0 = unsigned; captured with `start`.
REQ-005 SHALL have port `a`, input, 16 bits: multiplicand; captured with `start`.
REQ-006 SHALL have port `b`, input, 16 bits: multiplier; captured with `start`.
REQ-007 SHALL have port `busy`, output, 1 bit: high while an operation is in progress.
REQ-008 SHALL have port `done`, output, 1 bit: one-cycle pulse when the result is valid.
REQ-009 SHALL have port `product`, output, 32 bits: result; held until the next accepted `start`.
REQ-010 SHALL have port `overflow`, output, 1 bit: the result does not fit in 16 bits of the selected signedness; held with `product`.

Function
REQ-011 SHALL implement the states IDLE, CALC, FIX and DONE.
REQ-012 IDLE or DONE with `start`=1 SHALL capture the following at the same edge, then go to CALC:
- |a| and |b| (the magnitude when `sign`=1 and the operand is negative, otherwise the raw value);
- a negate flag = `sign` & (a[15] ^ b[15]);
- a 5-bit iteration count, cleared to 0.
REQ-013 CALC SHALL run exactly 16 iterations, one per cycle. Each iteration:
- if the multiplier LSB = 1, {carry, acc_hi} = acc_hi + |a|, 17 bits;
- then {carry, acc_hi, mplr} shifts right by 1.
REQ-014 After the 16th iteration, CALC SHALL go to FIX.
REQ-015 FIX SHALL apply the 32-bit two's-complement negate if the negate flag is set, compute `overflow`, register `product`, and go to DONE.
REQ-016 DONE SHALL assert `done`=1 for exactly one cycle, then go to IDLE unless a new `start` is accepted (back-to-back operation).
REQ-017 Latency: with `start` accepted at edge E, `done` SHALL be high in the cycle after edge E+17 and low at every other time.
REQ-018 `busy` SHALL be 1 in CALC and FIX, and 0 in IDLE and DONE.
REQ-019 `start` SHALL be ignored while `busy`=1; captured operands SHALL not change.
REQ-020 Overflow:
- unsigned: 1 when product[31:16] != 0;
- signed: 1 when product[31:15] is not all-equal.
REQ-021 0x8000 with `sign`=1 SHALL be treated as magnitude 32768; no internal wrap is allowed.
REQ-022 `product` and `overflow` SHALL not change between `done` and the next accepted `start`.

Reset
REQ-023 `rst_n`=0 at a clock edge SHALL force:
- state to IDLE;
- `busy`, `done`, `overflow` to 0;
- `product` to 0x00000000;
- the counter and accumulators to 0.
REQ-024 Reset mid-operation SHALL abort the operation with no `done` pulse. The first `start` after reset SHALL behave normally.

Configuration
REQ-025 Macro `SEQ_MUL_SAT_EN` defined: when `overflow`=1, `product` SHALL clamp to the 16-bit range:
- unsigned: 0x0000FFFF;
- signed positive: 0x00007FFF;
- signed negative: 0xFFFF8000.
REQ-026 Macro `SEQ_MUL_SAT_EN` undefined: `product` SHALL be the full 32-bit result. `overflow` SHALL be computed identically in both builds.

Structure
REQ-027 Package `seq_mul_pkg` SHALL hold:
- the state enumeration;
- the constants OP_W=16, PROD_W=32, ITER=16;
- the saturation constants.
REQ-028 The accumulate step SHALL use one sub-module, `mul_add17`: a 16-bit carry-lookahead adder in 4-bit groups with 17-bit sum (carry out).
REQ-029 The final negate and overflow logic SHALL be inline in the FIX state.

Verification
REQ-030 Unsigned max: sign=0, a=0xFFFF, b=0xFFFF -> product=0xFFFE0001, overflow=1, `done` after edge E+17; with SAT product=0x0000FFFF.
REQ-031 Signed mixed: sign=1, a=0xFFFD (-3), b=0x0005 -> product=0xFFFFFFF1, overflow=0.
REQ-032 Signed corner: sign=1, a=0x8000, b=0x8000 -> product=0x40000000, overflow=1; with SAT product=0x00007FFF.
REQ-033 Handshake:
- `start` pulsed during CALC -> ignored, first result unchanged;
- `start` in the DONE cycle with a=0x1234, b=0x0000 -> accepted, next product=0x00000000, overflow=0.
REQ-034 Reset at iteration 8: `rst_n`=0 for 1 edge -> busy=0, done=0, product=0x00000000, no `done` pulse; next start a=7, b=6 -> product=0x0000002A.
